// File: rtl/sram_2p_pkg.sv
// rtl/sram_2p_pkg.sv - shared types and March C- helpers for the two-port SRAM
package sram_2p_pkg;

  localparam int FAIL_CNT_W = 16;

  typedef enum logic [2:0] {M0, M1, M2, M3, M4, M5} march_elem_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} bist_state_e;
  typedef enum logic {RD, WR} march_op_e;

  // Background value the read of an element expects (M0 has no read)
  function automatic logic elem_rd_val(input march_elem_e e);
    return (e == M2) || (e == M4);
  endfunction

  // Background value an element writes (M5 has no write)
  function automatic logic elem_wr_val(input march_elem_e e);
    return (e == M1) || (e == M3);
  endfunction

  // Elements M3..M5 walk the address space downwards
  function automatic logic elem_down(input march_elem_e e);
    return (e == M3) || (e == M4) || (e == M5);
  endfunction

endpackage

// File: rtl/sram_2p_bm_array.sv
// rtl/sram_2p_bm_array.sv - behavioural two-port bit-masked array, read-before-write, latency-1 read data
module sram_2p_bm_array
  import sram_2p_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_we,
  input  logic                  a_re,
  input  logic                  a_hold,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  input  logic [DATA_WIDTH-1:0] a_bm,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_we,
  input  logic                  b_re,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  input  logic [DATA_WIDTH-1:0] b_bm,
  output logic [DATA_WIDTH-1:0] b_dout
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [DATA_WIDTH-1:0] a_old, b_old, a_new, b_new, ab_new;

  assign a_old  = mem[a_addr];
  assign b_old  = mem[b_addr];
  assign a_new  = (a_old & ~a_bm) | (a_din & a_bm);
  assign b_new  = (b_old & ~b_bm) | (b_din & b_bm);
  // Same-address double write: port A owns its masked bits, port B fills the rest
  assign ab_new = (b_new & ~a_bm) | (a_din & a_bm);

  // Array update; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (a_we && b_we && (a_addr == b_addr)) begin
      mem[a_addr] <= ab_new;
    end else begin
      if (a_we) mem[a_addr] <= a_new;
      if (b_we) mem[b_addr] <= b_new;
    end
  end

  // Read registers; a_hold keeps the visible port A data frozen while the engine reads
  always_ff @(posedge clk) begin
    if (rst) begin
      a_dout  <= '0;
      a_rdata <= '0;
      b_dout  <= '0;
    end else begin
      if (a_re) a_rdata <= a_old;
      if (a_re && !a_hold) a_dout <= a_old;
      if (b_re) b_dout <= b_old;
    end
  end

endmodule

// File: rtl/sram_2p_bm_march.sv
// rtl/sram_2p_bm_march.sv - two-port bit-masked SRAM with March C- BIST (option SRAM_2P_MARCH_FAIL_COUNT_EN)
module sram_2p_bm_march
  import sram_2p_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_MEN,
  input  logic                  A_WEN,
  input  logic                  A_REN,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_DIN,
  input  logic [DATA_WIDTH-1:0] A_BM,
  output logic [DATA_WIDTH-1:0] A_DOUT,
  input  logic                  B_MEN,
  input  logic                  B_WEN,
  input  logic                  B_REN,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_DIN,
  input  logic [DATA_WIDTH-1:0] B_BM,
  output logic [DATA_WIDTH-1:0] B_DOUT,
  input  logic                  BIST_START,
  output logic                  BIST_BUSY,
  output logic                  BIST_DONE,
  output logic                  BIST_FAIL,
  output logic [ADDR_WIDTH-1:0] BIST_FAIL_ADDR
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
  ,
  output logic [FAIL_CNT_W-1:0] BIST_FAIL_CNT
`endif
);

  bist_state_e           state_q, state_d;
  march_elem_e           elem_q, elem_d, elem_nx;
  march_op_e             op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_step, cmp_addr_q, cmp_addr_d;
  logic                  drain_q, drain_d, cmp_valid_q, cmp_valid_d, cmp_exp_q, cmp_exp_d;
  logic                  busy, last_addr, mismatch, eng_we, eng_re;
  logic [DATA_WIDTH-1:0] eng_din, a_rdata;
  logic                  fail_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
  logic [FAIL_CNT_W-1:0] fail_cnt_q;
`endif

  assign busy      = (state_q == RUN);
  assign mismatch  = busy && cmp_valid_q && (a_rdata != {DATA_WIDTH{cmp_exp_q}});
  assign elem_nx   = march_elem_e'(elem_q + 3'd1);
  assign last_addr = elem_down(elem_q) ? (addr_q == '0) : (addr_q == '1);
  assign addr_step = elem_down(elem_q) ? addr_q - ADDR_WIDTH'(1) : addr_q + ADDR_WIDTH'(1);

  // Engine state register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      elem_q      <= M0;
      op_q        <= WR;
      addr_q      <= '0;
      drain_q     <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_exp_q   <= 1'b0;
      cmp_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      elem_q      <= elem_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      drain_q     <= drain_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_exp_q   <= cmp_exp_d;
      cmp_addr_q  <= cmp_addr_d;
    end
  end

  // March sequencing: a read is compared the cycle after issue, the write of a pair shares that cycle
  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    addr_d      = addr_q;
    drain_d     = drain_q;
    cmp_valid_d = 1'b0;
    cmp_exp_d   = cmp_exp_q;
    cmp_addr_d  = cmp_addr_q;
    eng_we      = 1'b0;
    eng_re      = 1'b0;
    eng_din     = '0;
    case (state_q)
      IDLE, DONE: begin
        if (BIST_START) begin
          state_d = RUN;
          elem_d  = M0;
          op_d    = WR;
          addr_d  = '0;
          drain_d = 1'b0;
        end
      end
      RUN: begin
        if (drain_q) begin
          state_d = DONE;
        end else if (op_q == RD) begin
          eng_re      = 1'b1;
          cmp_valid_d = 1'b1;
          cmp_exp_d   = elem_rd_val(elem_q);
          cmp_addr_d  = addr_q;
          if (elem_q != M5)   op_d    = WR;
          else if (last_addr) drain_d = 1'b1;
          else                addr_d  = addr_step;
        end else begin
          eng_we  = 1'b1;
          eng_din = {DATA_WIDTH{elem_wr_val(elem_q)}};
          if (last_addr) begin
            elem_d = elem_nx;
            addr_d = elem_down(elem_nx) ? '1 : '0;
            op_d   = RD;
          end else begin
            addr_d = addr_step;
            op_d   = (elem_q == M0) ? WR : RD;
          end
        end
`ifndef SRAM_2P_MARCH_FAIL_COUNT_EN
        if (mismatch) state_d = DONE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Sticky result: first failing address kept, cleared by a new start
  always_ff @(posedge CLK) begin
    if (RST || (!busy && BIST_START)) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
      fail_cnt_q  <= '0;
`endif
    end else if (mismatch) begin
      fail_q <= 1'b1;
      if (!fail_q) fail_addr_q <= cmp_addr_q;
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
      if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + FAIL_CNT_W'(1);
`endif
    end
  end

  assign BIST_BUSY      = busy;
  assign BIST_DONE      = (state_q == DONE);
  assign BIST_FAIL      = fail_q;
  assign BIST_FAIL_ADDR = fail_addr_q;
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
  assign BIST_FAIL_CNT  = fail_cnt_q;
`endif

  sram_2p_bm_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk    (CLK),
    .rst    (RST),
    .a_we   (busy ? eng_we : (A_MEN & A_WEN)),
    .a_re   (busy ? eng_re : (A_MEN & A_REN & ~A_WEN)),
    .a_hold (busy),
    .a_addr (busy ? addr_q : A_ADDR),
    .a_din  (busy ? eng_din : A_DIN),
    .a_bm   (busy ? {DATA_WIDTH{1'b1}} : A_BM),
    .a_dout (A_DOUT),
    .a_rdata(a_rdata),
    .b_we   (~busy & B_MEN & B_WEN),
    .b_re   (~busy & B_MEN & B_REN & ~B_WEN),
    .b_addr (B_ADDR),
    .b_din  (B_DIN),
    .b_bm   (B_BM),
    .b_dout (B_DOUT)
  );

endmodule

// File: tb/tb_sram_2p_bm_march.sv
// tb/tb_sram_2p_bm_march.sv - self-checking bench for sram_2p_bm_march with a reference memory and March model
module tb_sram_2p_bm_march;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 16;

  logic          CLK;
  logic          RST;
  logic          A_MEN, A_WEN, A_REN, B_MEN, B_WEN, B_REN;
  logic [AW-1:0] A_ADDR, B_ADDR;
  logic [DW-1:0] A_DIN, A_BM, B_DIN, B_BM, A_DOUT, B_DOUT;
  logic          BIST_START, BIST_BUSY, BIST_DONE, BIST_FAIL;
  logic [AW-1:0] BIST_FAIL_ADDR;
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
  logic [15:0]   BIST_FAIL_CNT;
`endif

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] ref_mem [N];
  logic [DW-1:0] exp_a, exp_b;

  sram_2p_bm_march #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .A_MEN(A_MEN), .A_WEN(A_WEN), .A_REN(A_REN), .A_ADDR(A_ADDR),
    .A_DIN(A_DIN), .A_BM(A_BM), .A_DOUT(A_DOUT),
    .B_MEN(B_MEN), .B_WEN(B_WEN), .B_REN(B_REN), .B_ADDR(B_ADDR),
    .B_DIN(B_DIN), .B_BM(B_BM), .B_DOUT(B_DOUT),
    .BIST_START(BIST_START), .BIST_BUSY(BIST_BUSY), .BIST_DONE(BIST_DONE),
    .BIST_FAIL(BIST_FAIL), .BIST_FAIL_ADDR(BIST_FAIL_ADDR)
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
    , .BIST_FAIL_CNT(BIST_FAIL_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    {A_MEN, A_WEN, A_REN, B_MEN, B_WEN, B_REN, BIST_START} = '0;
    A_ADDR = '0; B_ADDR = '0; A_DIN = '0; B_DIN = '0; A_BM = '0; B_BM = '0;
  endtask

  // One functional cycle on both ports; model reads see pre-write contents, A's masked bits win
  task automatic drive_cycle(input logic am, input logic aw, input logic ar, input logic [AW-1:0] aa,
                             input logic [DW-1:0] ad, input logic [DW-1:0] abm,
                             input logic bmn, input logic bw, input logic br, input logic [AW-1:0] ba,
                             input logic [DW-1:0] bd, input logic [DW-1:0] bbm);
    A_MEN = am; A_WEN = aw; A_REN = ar; A_ADDR = aa; A_DIN = ad; A_BM = abm;
    B_MEN = bmn; B_WEN = bw; B_REN = br; B_ADDR = ba; B_DIN = bd; B_BM = bbm;
    step();
    if (am && ar && !aw)  exp_a = ref_mem[aa];
    if (bmn && br && !bw) exp_b = ref_mem[ba];
    if (bmn && bw) ref_mem[ba] = (ref_mem[ba] & ~bbm) | (bd & bbm);
    if (am && aw)  ref_mem[aa] = (ref_mem[aa] & ~abm) | (ad & abm);
    idle();
  endtask

  // Walks the March C- operation list; reads compare one cycle after issue, a stuck bit reads as 1
  function automatic void march_model(input int stuck_addr, input int stuck_bit, input bit cont,
                                      output int cycles, output int first_addr, output int nfails);
    logic [DW-1:0] m [N];
    int t;
    nfails = 0; first_addr = 0; t = 0;
    for (int e = 0; e < 6; e++) begin
      for (int i = 0; i < N; i++) begin
        int a;
        logic [DW-1:0] v;
        a = (e >= 3) ? (N - 1 - i) : i;
        if (e != 0) begin
          v = m[a];
          if (a == stuck_addr) v[stuck_bit] = 1'b1;
          if (v !== {DW{(e == 2) || (e == 4)}}) begin
            if (nfails == 0) first_addr = a;
            nfails++;
            if (!cont) begin
              cycles = t + 2;
              return;
            end
          end
          t++;
        end
        if (e != 5) begin
          m[a] = {DW{(e == 1) || (e == 3)}};
          t++;
        end
      end
    end
    cycles = t + 1;
  endfunction

  // Pulses START, checks the clears, then runs with random functional noise until BUSY drops or stop_at
  task automatic run_bist(input int stop_at, output int cycles);
    bit held_ok;
    BIST_START = 1'b1;
    step();
    BIST_START = 1'b0;
    n_tests++;
    if ({BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR} !== {1'b1, 1'b0, 1'b0, {AW{1'b0}}}) begin
      n_fail++;
      $display("FAIL start_clear: busy/done/fail/addr got %b%b%b %h want 100 0",
               BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR);
    end
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
    n_tests++;
    if (BIST_FAIL_CNT !== 16'd0) begin
      n_fail++;
      $display("FAIL start_cnt_clear: got %0d want 0", BIST_FAIL_CNT);
    end
`endif
    cycles = 0;
    held_ok = 1'b1;
    while (BIST_BUSY === 1'b1 && cycles < stop_at) begin
      if (A_DOUT !== exp_a || B_DOUT !== exp_b) held_ok = 1'b0;
      {A_MEN, A_WEN, A_REN, B_MEN, B_WEN, B_REN, BIST_START} = 7'($urandom);
      A_ADDR = AW'($urandom); B_ADDR = AW'($urandom);
      A_DIN = $urandom; B_DIN = $urandom; A_BM = $urandom; B_BM = $urandom;
      cycles++;
      step();
    end
    idle();
    n_tests++;
    if (!held_ok) begin
      n_fail++;
      $display("FAIL dout_hold_in_run: DOUT changed during BUSY, now A %h B %h want A %h B %h",
               A_DOUT, B_DOUT, exp_a, exp_b);
    end
  endtask

  task automatic readback_all(input string tag);
    int bad = 0;
    for (int i = 0; i < N; i++) begin
      drive_cycle(1, 0, 1, AW'(N - 1 - i), '0, '0, 1, 0, 1, AW'(i), '0, '0);
      if (A_DOUT !== exp_a || B_DOUT !== exp_b) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s: %0d readback cycles differ from model (last A %h B %h want A %h B %h)",
               tag, bad, A_DOUT, B_DOUT, exp_a, exp_b);
    end
  endtask

  task automatic test_reset();
    idle();
    RST = 1'b1;
    step(); step();
    n_tests++;
    if ({A_DOUT, B_DOUT, BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: A %h B %h busy %b done %b fail %b addr %h want all 0",
               A_DOUT, B_DOUT, BIST_BUSY, BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR);
    end
    RST = 1'b0;
    exp_a = '0; exp_b = '0;
    step();
    for (int i = 0; i < N; i++) drive_cycle(1, 1, 0, AW'(i), $urandom, '1, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic test_masked_write();
    drive_cycle(1, 1, 0, 4'd3, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0, 0, '0, '0, '0);
    drive_cycle(1, 1, 0, 4'd3, 32'h00000000, 32'h0000FFFF, 0, 0, 0, '0, '0, '0);
    drive_cycle(0, 0, 0, '0, '0, '0, 1, 0, 1, 4'd3, '0, '0);
    n_tests++;
    if (B_DOUT !== 32'hDEAD0000) begin
      n_fail++;
      $display("FAIL masked_write: got %h want DEAD0000", B_DOUT);
    end
    // DOUT holds with no read; WEN&REN is a write only
    drive_cycle(0, 0, 0, '0, '0, '0, 1, 1, 1, 4'd3, 32'h12345678, '1);
    n_tests++;
    if (B_DOUT !== 32'hDEAD0000) begin
      n_fail++;
      $display("FAIL wen_ren_hold: got %h want DEAD0000", B_DOUT);
    end
  endtask

  task automatic test_collision();
    logic [DW-1:0] old2;
    drive_cycle(1, 1, 0, 4'd7, 32'h11111111, 32'hFFFF0000, 1, 1, 0, 4'd7, 32'h22222222, 32'hFFFFFFFF);
    drive_cycle(1, 0, 1, 4'd7, '0, '0, 0, 0, 0, '0, '0, '0);
    n_tests++;
    if (A_DOUT !== 32'h11112222) begin
      n_fail++;
      $display("FAIL collision_ww: got %h want 11112222", A_DOUT);
    end
    old2 = ref_mem[2];
    drive_cycle(1, 1, 0, 4'd2, ~old2, '1, 1, 0, 1, 4'd2, '0, '0);
    n_tests++;
    if (B_DOUT !== old2) begin
      n_fail++;
      $display("FAIL read_before_write: got %h want %h", B_DOUT, old2);
    end
    drive_cycle(0, 0, 0, '0, '0, '0, 1, 0, 1, 4'd2, '0, '0);
    n_tests++;
    if (B_DOUT !== ~old2) begin
      n_fail++;
      $display("FAIL rbw_newdata: got %h want %h", B_DOUT, ~old2);
    end
  endtask

  task automatic test_random_traffic(input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      drive_cycle(1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), $urandom, $urandom,
                  1'($urandom), 1'($urandom), 1'($urandom), AW'($urandom), $urandom, $urandom);
      if (A_DOUT !== exp_a || B_DOUT !== exp_b) begin
        bad++;
        if (bad < 4) $display("FAIL random_dout: cycle %0d A %h B %h want A %h B %h",
                              i, A_DOUT, B_DOUT, exp_a, exp_b);
      end
    end
    n_tests++;
    if (bad != 0) n_fail++;
  endtask

  task automatic test_reset_mid_bist();
    int cyc, ecyc, eaddr, ecnt;
    drive_cycle(1, 1, 0, 4'd0, 32'hA5A5A5A5, '1, 0, 0, 0, '0, '0, '0);
    drive_cycle(1, 0, 1, 4'd0, '0, '0, 1, 0, 1, 4'd0, '0, '0);
    run_bist(40, cyc);
    RST = 1'b1;
    step();
    n_tests++;
    if ({BIST_BUSY, BIST_DONE, BIST_FAIL, A_DOUT, B_DOUT} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_bist: busy %b done %b fail %b A %h B %h want all 0",
               BIST_BUSY, BIST_DONE, BIST_FAIL, A_DOUT, B_DOUT);
    end
    RST = 1'b0;
    exp_a = '0; exp_b = '0;
    step();
    march_model(-1, 0, 1'b0, ecyc, eaddr, ecnt);
    run_bist(1000, cyc);
    n_tests++;
    if (cyc != ecyc || BIST_DONE !== 1'b1 || BIST_FAIL !== 1'b0) begin
      n_fail++;
      $display("FAIL rerun_after_reset: busy %0d done %b fail %b want %0d 1 0", cyc, BIST_DONE, BIST_FAIL, ecyc);
    end
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
  endtask

  task automatic test_bist_clean();
    int cyc, ecyc, eaddr, ecnt;
    for (int i = 0; i < N; i++) drive_cycle(1, 1, 0, AW'(i), $urandom, '1, 0, 0, 0, '0, '0, '0);
    drive_cycle(1, 0, 1, 4'd5, '0, '0, 1, 0, 1, 4'd9, '0, '0);
    march_model(-1, 0, 1'b0, ecyc, eaddr, ecnt);
    run_bist(1000, cyc);
    n_tests++;
    if (cyc != ecyc) begin
      n_fail++;
      $display("FAIL clean_busy_len: got %0d want %0d", cyc, ecyc);
    end
    n_tests++;
    if (BIST_DONE !== 1'b1 || BIST_FAIL !== 1'b0 || BIST_BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_result: done %b fail %b busy %b want 1 0 0", BIST_DONE, BIST_FAIL, BIST_BUSY);
    end
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    readback_all("clean_contents");
  endtask

  task automatic test_bist_fault();
    int cyc, ecyc, eaddr, ecnt;
    bit cont;
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
    cont = 1'b1;
`else
    cont = 1'b0;
`endif
    force dut.u_array.mem[5][3] = 1'b1;
    march_model(5, 3, cont, ecyc, eaddr, ecnt);
    run_bist(1000, cyc);
    n_tests++;
    if (cyc != ecyc) begin
      n_fail++;
      $display("FAIL fault_busy_len: got %0d want %0d", cyc, ecyc);
    end
    n_tests++;
    if (BIST_DONE !== 1'b1 || BIST_FAIL !== 1'b1 || BIST_FAIL_ADDR !== AW'(eaddr)) begin
      n_fail++;
      $display("FAIL fault_result: done %b fail %b addr %0d want 1 1 %0d",
               BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR, eaddr);
    end
`ifdef SRAM_2P_MARCH_FAIL_COUNT_EN
    n_tests++;
    if (BIST_FAIL_CNT !== 16'(ecnt)) begin
      n_fail++;
      $display("FAIL fault_count: got %0d want %0d", BIST_FAIL_CNT, ecnt);
    end
`endif
    release dut.u_array.mem[5][3];
  endtask

  task automatic test_restart();
    int cyc, ecyc, eaddr, ecnt;
    march_model(-1, 0, 1'b0, ecyc, eaddr, ecnt);
    run_bist(1000, cyc);
    n_tests++;
    if (cyc != ecyc || BIST_DONE !== 1'b1 || BIST_FAIL !== 1'b0 || BIST_FAIL_ADDR !== '0) begin
      n_fail++;
      $display("FAIL restart_run: busy %0d done %b fail %b addr %0d want %0d 1 0 0",
               cyc, BIST_DONE, BIST_FAIL, BIST_FAIL_ADDR, ecyc);
    end
    for (int i = 0; i < N; i++) ref_mem[i] = '0;
    readback_all("restart_contents");
  endtask

  initial begin
    RST = 1'b1;
    idle();
    test_reset();
    test_masked_write();
    test_collision();
    test_random_traffic(300);
    test_reset_mid_bist();
    test_bist_clean();
    test_bist_fault();
    test_restart();
    test_random_traffic(100);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
